// File: rtl/mmcm_rst_seq_pkg.sv
// Shared types and constants for the MMCM reset/lock sequencer.
package mmcm_rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    WAIT_LOCK,
    STABLE,
    READY,
    FAIL
  } seq_state_e;

  localparam int RETRY_W = 4;

  function automatic int cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mmcm_rst_seq_ch.sv
// One sequencer channel: lock synchroniser, reset/lock FSM, counters and status flags.
module mmcm_rst_seq_ch
  import mmcm_rst_seq_pkg::*;
#(
  parameter int RST_HOLD    = 16,
  parameter int LOCK_TMO    = 65535,
  parameter int LOCK_STABLE = 256,
  parameter int MAX_RETRY   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               eos,
  input  logic               up_rdy,
  input  logic               locked,
  input  logic               force_rst,
  output logic               mmcm_rst,
  output logic               ch_ready,
  output logic               lock_fail,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int HW = cnt_w(RST_HOLD);
  localparam int TW = cnt_w(LOCK_TMO);
  localparam int SW = cnt_w(LOCK_STABLE);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [TW-1:0]      TMO_LAST  = TW'(LOCK_TMO - 1);
  localparam logic [SW-1:0]      STB_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  seq_state_e         state_q, state_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0]      stb_cnt_q, stb_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lost_q, lost_d;
  logic               mmcm_rst_q, mmcm_rst_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               lk_s1_q, lk_s2_q;
  logic               tmo_hit, retry_full;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    stb_cnt_d  = stb_cnt_q;
    retry_d    = retry_q;
    lost_d     = lost_q;
    tmo_hit    = (tmo_cnt_q == TMO_LAST);
    retry_full = (retry_q == RETRY_MAX);

    if (force_rst && state_q != IDLE) begin
      state_d    = HOLD;
      hold_cnt_d = '0;
      tmo_cnt_d  = '0;
      stb_cnt_d  = '0;
      retry_d    = '0;
      lost_d     = 1'b0;
    end else if (!up_rdy && state_q != IDLE) begin
      // Upstream clock gone: park in HOLD with counters frozen until it returns.
      state_d = HOLD;
      if (state_q != HOLD) hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (eos && up_rdy) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
        HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d   = WAIT_LOCK;
            tmo_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        WAIT_LOCK, STABLE: begin
          // Timeout is checked first so it wins over a same-cycle lock event.
          if (tmo_hit) begin
            if (retry_full) begin
              state_d = FAIL;
            end else begin
              state_d    = HOLD;
              hold_cnt_d = '0;
              if (retry_q != '1) retry_d = retry_q + 1'b1;
            end
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (state_q == WAIT_LOCK) begin
              if (lk_s2_q) begin
                state_d   = STABLE;
                stb_cnt_d = '0;
              end
            end else if (!lk_s2_q) begin
              state_d = WAIT_LOCK;
            end else if (stb_cnt_q == STB_LAST) begin
              state_d = READY;
            end else begin
              stb_cnt_d = stb_cnt_q + 1'b1;
            end
          end
        end
        READY: begin
          if (!lk_s2_q) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
            lost_d     = 1'b1;
            retry_d    = '0;
          end
        end
        FAIL: ;
        default: state_d = IDLE;
      endcase
    end

    mmcm_rst_d = (state_d == IDLE) || (state_d == HOLD) || (state_d == FAIL);
    ready_d    = (state_d == READY);
    fail_d     = (state_d == FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      stb_cnt_q  <= '0;
      retry_q    <= '0;
      lost_q     <= 1'b0;
      mmcm_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
      lk_s1_q    <= 1'b0;
      lk_s2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      stb_cnt_q  <= stb_cnt_d;
      retry_q    <= retry_d;
      lost_q     <= lost_d;
      mmcm_rst_q <= mmcm_rst_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
      lk_s1_q    <= locked;
      lk_s2_q    <= lk_s1_q;
    end
  end

  assign mmcm_rst  = mmcm_rst_q;
  assign ch_ready  = ready_q;
  assign lock_fail = fail_q;
  assign lock_lost = lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: rtl/mmcm_rst_seq.sv
// Top-level MMCM reset/lock sequencer: EOS sync, N channels, status packing.
// Optional MMCM_SEQ_CASCADE_EN: channel k>0 sequences only while channel k-1 is READY.
module mmcm_rst_seq
  import mmcm_rst_seq_pkg::*;
#(
  parameter int N_MMCM      = 2,
  parameter int RST_HOLD    = 16,
  parameter int LOCK_TMO    = 65535,
  parameter int LOCK_STABLE = 256,
  parameter int MAX_RETRY   = 7
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        EOS,
  input  logic [N_MMCM-1:0]           LOCKED,
  input  logic [N_MMCM-1:0]           FORCE_RST,
  output logic [N_MMCM-1:0]           MMCM_RST,
  output logic [N_MMCM-1:0]           CH_READY,
  output logic                        ALL_LOCKED,
  output logic [N_MMCM-1:0]           LOCK_FAIL,
  output logic [N_MMCM-1:0]           LOCK_LOST,
  output logic [RETRY_W*N_MMCM-1:0]   RETRY_CNT
);

  logic              eos_s1_q, eos_s2_q;
  logic              all_locked_q, all_locked_d;
  logic [N_MMCM-1:0] ch_rdy;
  logic [N_MMCM-1:0] up_rdy;

  always_comb begin
    all_locked_d = &ch_rdy;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      eos_s1_q     <= 1'b0;
      eos_s2_q     <= 1'b0;
      all_locked_q <= 1'b0;
    end else begin
      eos_s1_q     <= EOS;
      eos_s2_q     <= eos_s1_q;
      all_locked_q <= all_locked_d;
    end
  end

  for (genvar k = 0; k < N_MMCM; k++) begin : g_ch
    if (k == 0) begin : g_first
      assign up_rdy[k] = 1'b1;
    end else begin : g_next
`ifdef MMCM_SEQ_CASCADE_EN
      assign up_rdy[k] = ch_rdy[k-1];
`else
      assign up_rdy[k] = 1'b1;
`endif
    end

    mmcm_rst_seq_ch #(
      .RST_HOLD    (RST_HOLD),
      .LOCK_TMO    (LOCK_TMO),
      .LOCK_STABLE (LOCK_STABLE),
      .MAX_RETRY   (MAX_RETRY)
    ) u_ch (
      .clk       (CLK),
      .rst       (RST),
      .eos       (eos_s2_q),
      .up_rdy    (up_rdy[k]),
      .locked    (LOCKED[k]),
      .force_rst (FORCE_RST[k]),
      .mmcm_rst  (MMCM_RST[k]),
      .ch_ready  (ch_rdy[k]),
      .lock_fail (LOCK_FAIL[k]),
      .lock_lost (LOCK_LOST[k]),
      .retry_cnt (RETRY_CNT[RETRY_W*k +: RETRY_W])
    );
  end

  assign CH_READY   = ch_rdy;
  assign ALL_LOCKED = all_locked_q;

endmodule

// File: tb/tb_mmcm_rst_seq.sv
// Directed self-checking bench for mmcm_rst_seq (N=2, hold 16, timeout 1000, stable 64, retry 3).
module tb_mmcm_rst_seq;
  import mmcm_rst_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       eos;
  logic [1:0] locked;
  logic [1:0] force_rst;
  logic [1:0] mmcm_rst, ch_ready, lock_fail, lock_lost;
  logic       all_locked;
  logic [7:0] retry_cnt;
  int         checks = 0;
  int         failures = 0;
  logic       saw_ready;

  mmcm_rst_seq #(
    .N_MMCM(2), .RST_HOLD(16), .LOCK_TMO(1000), .LOCK_STABLE(64), .MAX_RETRY(3)
  ) dut (
    .CLK(clk), .RST(rst), .EOS(eos), .LOCKED(locked), .FORCE_RST(force_rst),
    .MMCM_RST(mmcm_rst), .CH_READY(ch_ready), .ALL_LOCKED(all_locked),
    .LOCK_FAIL(lock_fail), .LOCK_LOST(lock_lost), .RETRY_CNT(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mmcm_rst"}, 32'(mmcm_rst), 32'h3);
    chk({tag, "_ready"}, 32'(ch_ready), 32'h0);
    chk({tag, "_all"}, 32'(all_locked), 32'h0);
    chk({tag, "_fail"}, 32'(lock_fail), 32'h0);
    chk({tag, "_lost"}, 32'(lock_lost), 32'h0);
    chk({tag, "_retry"}, 32'(retry_cnt), 32'h0);
  endtask

  initial begin
    rst = 1'b1; eos = 1'b0; locked = 2'b00; force_rst = 2'b00;
    step(3);
    chk_reset_vals("por");
    rst = 1'b0;
    step(2);
    force_rst = 2'b11;
    step(1);
    force_rst = 2'b00;
    step(20);
    chk("idle_force_ignored", 32'(mmcm_rst), 32'h3);

`ifdef MMCM_SEQ_CASCADE_EN
    eos = 1'b1; locked = 2'b11;
    step(19);
    chk("casc_ch0_release", 32'(mmcm_rst), 32'h2);
    step(65);
    chk("casc_ch0_ready", 32'(ch_ready), 32'h1);
    chk("casc_ch1_held", 32'(mmcm_rst), 32'h2);
    step(16);
    chk("casc_ch1_hold_end", 32'(mmcm_rst), 32'h2);
    step(1);
    chk("casc_ch1_release", 32'(mmcm_rst), 32'h0);
`else
    // Nominal bring-up
    eos = 1'b1;
    step(18);
    chk("nom_rst_hi_18", 32'(mmcm_rst), 32'h3);
    step(1);
    chk("nom_rst_fall_19", 32'(mmcm_rst), 32'h0);
    step(50);
    locked = 2'b11;
    step(66);
    chk("nom_ready_66", 32'(ch_ready), 32'h0);
    step(1);
    chk("nom_ready_67", 32'(ch_ready), 32'h3);
    chk("nom_all_lag", 32'(all_locked), 32'h0);
    chk("nom_retry", 32'(retry_cnt), 32'h0);
    step(1);
    chk("nom_all_locked", 32'(all_locked), 32'h1);

    // Lock loss on channel 1
    locked = 2'b01;
    step(2);
    chk("loss_ready_2", 32'(ch_ready), 32'h3);
    step(1);
    chk("loss_ready_3", 32'(ch_ready), 32'h1);
    chk("loss_mmcm_rst_3", 32'(mmcm_rst), 32'h2);
    chk("loss_lost", 32'(lock_lost), 32'h2);
    step(1);
    chk("loss_all_drop", 32'(all_locked), 32'h0);
    step(1);
    locked = 2'b11;
    step(78);
    chk("relock_83", 32'(ch_ready), 32'h1);
    step(1);
    chk("relock_84", 32'(ch_ready), 32'h3);
    chk("lost_sticky", 32'(lock_lost), 32'h2);
    force_rst = 2'b10;
    step(1);
    force_rst = 2'b00;
    chk("force_ready_rst", 32'(mmcm_rst), 32'h2);
    chk("force_clr_lost", 32'(lock_lost), 32'h0);

    // Channel 0 never locks: retries then FAIL, channel 1 unaffected
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    locked = 2'b10;
    step(1018);
    chk("tmo1_pre", 32'(mmcm_rst), 32'h0);
    step(1);
    chk("tmo1_rst", 32'(mmcm_rst), 32'h1);
    chk("tmo1_retry", 32'(retry_cnt), 32'h01);
    step(15);
    chk("tmo1_hold_15", 32'(mmcm_rst), 32'h1);
    step(1);
    chk("tmo1_hold_16", 32'(mmcm_rst), 32'h0);
    step(1000);
    chk("tmo2_retry", 32'(retry_cnt), 32'h02);
    step(1016);
    chk("tmo3_retry", 32'(retry_cnt), 32'h03);
    step(1015);
    chk("tmo4_pre_fail", 32'(lock_fail), 32'h0);
    step(1);
    chk("tmo4_fail", 32'(lock_fail), 32'h1);
    chk("tmo4_retry", 32'(retry_cnt), 32'h03);
    chk("tmo4_mmcm_rst", 32'(mmcm_rst), 32'h1);
    chk("tmo4_ch1_ready", 32'(ch_ready), 32'h2);

    // FORCE_RST out of FAIL, then again mid WAIT_LOCK
    force_rst = 2'b01;
    step(1);
    force_rst = 2'b00;
    chk("ffail_rst", 32'(mmcm_rst), 32'h1);
    chk("ffail_clr", 32'(lock_fail), 32'h0);
    chk("ffail_retry", 32'(retry_cnt), 32'h0);
    step(15);
    chk("ffail_hold_15", 32'(mmcm_rst), 32'h1);
    step(1);
    chk("ffail_hold_16", 32'(mmcm_rst), 32'h0);
    step(1000);
    chk("fwait_retry_pre", 32'(retry_cnt), 32'h01);
    step(216);
    force_rst = 2'b01;
    step(1);
    force_rst = 2'b00;
    chk("fwait_rst", 32'(mmcm_rst), 32'h1);
    chk("fwait_retry_clr", 32'(retry_cnt), 32'h0);

    // Chattering lock never reaches READY; timeout still fires
    step(16);
    chk("chat_release", 32'(mmcm_rst), 32'h0);
    saw_ready = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      step(1);
      if (ch_ready[0]) saw_ready = 1'b1;
      if (i == 999) chk("chat_pre_tmo", 32'(mmcm_rst[0]), 32'h0);
      if (i == 1000) begin
        chk("chat_tmo", 32'(mmcm_rst[0]), 32'h1);
        chk("chat_retry", 32'(retry_cnt), 32'h01);
      end
      if (i % 30 == 0) locked[0] = ~locked[0];
    end
    chk("chat_never_ready", 32'(saw_ready), 32'h0);

    // RST while channel 0 is in STABLE
    locked = 2'b11;
    step(36);
    chk("stable_pre_rst", 32'(ch_ready), 32'h2);
    rst = 1'b1;
    step(1);
    chk_reset_vals("midrst");
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmcm_rst_seq.md
# mmcm_rst_seq

Parametrised reset/lock sequencer for up to N clock-management tiles (MMCMs) in the clock-sources area. After end-of-configuration it holds each MMCM in reset for a programmed time, then waits for lock with a timeout. It requires lock to be stable before declaring the channel ready, and retries or flags failure. Lock loss after ready is detected and re-sequenced, and per-channel status goes to slow control.

## Interface
Parameters:
- N_MMCM, 2: number of sequenced MMCM channels (1–8).
- RST_HOLD, 16: cycles MMCM_RST is held high per attempt (≥2).
- LOCK_TMO, 65535: cycles allowed from reset release to READY.
- LOCK_STABLE, 256: consecutive synchronised-lock cycles required before READY. Must be < LOCK_TMO.
- MAX_RETRY, 7: timeouts tolerated before FAIL (≤15).

Ports:
- CLK  in  1  free-running sequencer clock (startup clock).
- RST  in  1  synchronous, active-high reset.
- EOS  in  1  end-of-startup; asynchronous, 2-FF synchronised internally.
- LOCKED  in  N_MMCM  MMCM lock outputs; asynchronous, 2-FF synchronised per bit.
- FORCE_RST  in  N_MMCM  per-channel restart request, single-cycle pulse, synchronous.
- MMCM_RST  out  N_MMCM  reset to each MMCM.
- CH_READY  out  N_MMCM  channel in READY.
- ALL_LOCKED  out  1  AND of CH_READY, registered.
- LOCK_FAIL  out  N_MMCM  channel in FAIL.
- LOCK_LOST  out  N_MMCM  sticky: lock dropped while READY.
- RETRY_CNT  out  4*N_MMCM  per-channel timeout count, channel k at bits [4k+3:4k].

## Operation
Each channel has an independent FSM:
- IDLE: MMCM_RST=1. Goes to HOLD when synchronised EOS=1.
- HOLD: MMCM_RST=1 for exactly RST_HOLD cycles, then goes to WAIT_LOCK. The timeout counter clears on entry to WAIT_LOCK.
- WAIT_LOCK: MMCM_RST=0 and the timeout counter runs. Goes to STABLE when synchronised lock=1, with the stable counter cleared.
- STABLE: the timeout counter keeps running. The stable counter increments while lock=1.
  - Lock=0: back to WAIT_LOCK, timeout not cleared, retry not incremented.
  - Stable counter reaching LOCK_STABLE: go to READY.
- Timeout: the counter reaches LOCK_TMO in WAIT_LOCK or STABLE.
  - If RETRY_CNT==MAX_RETRY: go to FAIL.
  - Otherwise RETRY_CNT+1 and go to HOLD.
- READY: CH_READY=1, MMCM_RST=0. On lock=0: set LOCK_LOST, clear RETRY_CNT, go to HOLD.
- FAIL: MMCM_RST=1 and LOCK_FAIL=1. Terminal; only FORCE_RST or RST exits.

FORCE_RST[k] is accepted in any state except IDLE and has priority over every other transition. It:
- moves channel k to HOLD,
- clears RETRY_CNT[k], LOCK_LOST[k] and the counters.

FORCE_RST is ignored in IDLE.

Counters size to $clog2(limit+1). RETRY_CNT saturates and never wraps.

## Timing
- Reset values:
  - MMCM_RST all 1; state IDLE.
  - CH_READY, ALL_LOCKED, LOCK_FAIL, LOCK_LOST all 0; RETRY_CNT 0.
- RST asserted mid-operation returns every channel to IDLE on the next edge, with all outputs at reset values.
- All outputs are registered.
- Latencies:
  - EOS input rise to first MMCM_RST fall: 2 (sync) + 1 + RST_HOLD cycles.
  - LOCKED rise (held) to CH_READY rise: 2 + LOCK_STABLE + 1 cycles.
  - ALL_LOCKED lags the last CH_READY by 1 cycle.
  - LOCKED fall in READY to CH_READY=0 and MMCM_RST=1: 3 cycles.
- Simultaneous timeout and lock rise in the same cycle: the timeout wins.

## Configuration
- MMCM_SEQ_CASCADE_EN defined: channel k>0 leaves IDLE only when EOS=1 and CH_READY[k-1]=1, for cascaded MMCMs fed from an upstream MMCM output. If channel k-1 later leaves READY, channel k is forced to HOLD and held there, counters frozen, until CH_READY[k-1] returns.
- Undefined: all channels leave IDLE on the same EOS cycle and are fully independent.

## Structure
- Package mmcm_rst_seq_pkg holds:
  - the state enum (IDLE, HOLD, WAIT_LOCK, STABLE, READY, FAIL),
  - the RETRY_W=4 constant,
  - the counter-width function.
- Sub-module mmcm_rst_seq_ch: one channel's synchroniser, FSM, counters and status, with upstream-ready input for cascade mode. The top level generates N_MMCM instances, synchronises EOS, packs RETRY_CNT and registers ALL_LOCKED.

## Test plan
Directed scenarios use N_MMCM=2, RST_HOLD=16, LOCK_TMO=1000, LOCK_STABLE=64, MAX_RETRY=3.
1. Nominal:
   - Stimulus: EOS rises at cycle 0; LOCKED=2'b11 rises 50 cycles after MMCM_RST falls.
   - Required: MMCM_RST falls at cycle 19; CH_READY=2'b11 exactly 67 cycles after LOCKED; ALL_LOCKED 1 cycle later.
2. Timeout/fail:
   - Stimulus: LOCKED[0] held 0.
   - Required: 4 MMCM_RST[0] pulses of 16 cycles; RETRY_CNT[3:0]=3 and LOCK_FAIL[0]=1 after the 4th timeout; channel 1 unaffected.
3. Chatter:
   - Stimulus: LOCKED toggles every 30 cycles after release.
   - Required: never READY; timeout at 1000 cycles; RETRY_CNT increments by 1.
4. Lock loss:
   - Stimulus: drop LOCKED[1] for 5 cycles while READY.
   - Required: CH_READY[1]=0 and MMCM_RST[1]=1 after 3 cycles; LOCK_LOST[1]=1 sticky; re-READY after relock.
5. FORCE_RST:
   - Stimulus: pulse FORCE_RST[0] in FAIL, and again mid WAIT_LOCK.
   - Required: HOLD next cycle; RETRY_CNT and LOCK_LOST cleared.
   - Stimulus: pulse FORCE_RST in IDLE. Required: ignored.
6. RST and cascade:
   - Stimulus: RST mid STABLE. Required: all outputs return to reset values next edge.
   - With MMCM_SEQ_CASCADE_EN: channel 1 MMCM_RST stays 1 until CH_READY[0]=1.
